// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential shift-add multiplier.
package mult_pkg;

  localparam int DEF_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter must also hold W itself, the value reached after the last row.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DEF_KW = cnt_w(DEF_W);

endpackage

// File: rtl/pp_row.sv
// One partial-product row: multiplicand gated by a single multiplier bit.
module pp_row
  import mult_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] m,
  input  logic         q,
  output logic [W-1:0] pp
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign pp[i] = m[i] & q;
  end

endmodule

// File: rtl/seq_mult_4bit.sv
// Sequential unsigned multiplier: one partial-product row per RUN cycle,
// registered product/busy/done with fixed W+1 edge latency.
module seq_mult_4bit
  import mult_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int KW = cnt_w(W);

  state_e         state, state_nx;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] acc;
  logic [KW-1:0]  k;

  logic [W-1:0]   b_sh;
  logic           q_bit;
  logic [W-1:0]   row;
  logic [2*W-1:0] row_ext;
  logic           last_step;

  logic           busy_d, done_d, load_prod;

  assign b_sh      = b_q >> k;
  assign q_bit     = b_sh[0];
  assign last_step = (k == KW'(W - 1));

  pp_row #(.W(W)) u_pp_row (
    .m  (a_q),
    .q  (q_bit),
    .pp (row)
  );

  assign row_ext = {{W{1'b0}}, row} << k;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_step) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail it by one
  // edge; this lets IDLE overlap the done pulse and accept a back-to-back start.
  always_comb begin
    busy_d    = (state != IDLE);
    done_d    = (state == DONE);
    load_prod = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      k       <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (load_prod) product <= acc;
      case (state)
        IDLE: if (start) begin
          a_q <= a;
          b_q <= b;
          acc <= '0;
          k   <= '0;
        end
        RUN: begin
          acc <= acc + row_ext;
          k   <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_4bit.sv
// Directed bench for seq_mult_4bit: latency, hold, start handling, reset abort, full sweep.
module tb_seq_mult_4bit;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] product;
  logic           busy, done;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] last_prod;

  seq_mult_4bit #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Called at a negedge; the next posedge samples start. Returns at the
  // negedge after the done edge, so another call is back-to-back.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] want);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y;
    chk("e0_busy", 32'(busy), 32'd0);
    chk("e0_done", 32'(done), 32'd0);
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'(e == 5));
      chk("run_prod", 32'(product), (e == 5) ? 32'(want) : 32'(last_prod));
    end
    last_prod = want;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; a = 4'd3; b = 4'd5;
    repeat (2) @(negedge clk);
    chk("rst_prod", 32'(product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    rst_n = 1'b1; last_prod = '0;
    do_op(4'd3, 4'd5, 8'd15);
    @(negedge clk);
    chk("e6_busy", 32'(busy), 32'd0);
    chk("e6_done", 32'(done), 32'd0);
    chk("e6_prod", 32'(product), 32'd15);
    repeat (3) @(negedge clk);
    chk("hold_prod", 32'(product), 32'd15);
    chk("hold_busy", 32'(busy), 32'd0);

    do_op(4'd15, 4'd15, 8'd225);
    do_op(4'd0, 4'd9, 8'd0);
    @(negedge clk);
    chk("zero_idle", 32'(busy), 32'd0);

    // start held high; operands change mid-run and feed the second product
    a = 4'd2; b = 4'd6; start = 1'b1;
    for (int e = 0; e <= 11; e++) begin
      @(negedge clk);
      if (e == 1) begin a = 4'd7; b = 4'd7; end
      chk("hold_done", 32'(done), 32'(e == 5 || e == 11));
      chk("hold_busy", 32'(busy), 32'(e != 0 && e != 6));
      chk("hold_prod", 32'(product), (e < 5) ? 32'(last_prod) : (e < 11) ? 32'd12 : 32'd49);
    end
    start = 1'b0; last_prod = 8'd49;

    // reset mid-run discards the operation
    a = 4'd9; b = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_prod", 32'(product), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst_n = 1'b1; last_prod = '0;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      chk("abort_nodone", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    do_op(4'd9, 4'd9, 8'd81);
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        do_op(W'(i), W'(j), (2*W)'(i * j));
    @(negedge clk);
    chk("sweep_busy", 32'(busy), 32'd0);
    chk("sweep_done", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_4bit.md
SEQ_MULT_4BIT -- requirements
Module: seq_mult_4bit

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, W bits: multiplicand (unsigned).
REQ-006 The block SHALL have port b, input, W bits: multiplier (unsigned).
REQ-007 The block SHALL have port product, output, 2W bits: registered result.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking product valid.

Function
REQ-010 The FSM SHALL have states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1 at a rising edge, the block SHALL latch a and b, clear the accumulator, clear the step counter and enter RUN.
REQ-012 In IDLE with start=0, the block SHALL hold all state, including product.
REQ-013 Each RUN cycle with step k SHALL compute the partial-product row (a_latched AND b_latched[k] replicated W times).
REQ-014 Each RUN cycle SHALL add that row, zero-extended to 2W bits and shifted left by k, into the accumulator; no overflow is possible at 2W bits.
REQ-015 Each RUN cycle SHALL then increment k.
REQ-016 After exactly W RUN cycles (k = W-1 processed), the FSM SHALL load product from the accumulator and enter DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-018 Latency SHALL be fixed: with start sampled at edge 0, done=1 and the final product are visible after edge W+1 (edge 5 for W=4).
REQ-019 start SHALL be ignored in RUN and DONE; a and b changes after the start edge SHALL NOT affect the result.
REQ-020 product SHALL hold its value until the next result is loaded; it SHALL NOT show intermediate accumulator values.
REQ-021 A start sampled in IDLE in the cycle immediately after DONE SHALL be accepted (back-to-back throughput of W+2 cycles per result).
REQ-022 Operands of zero SHALL still take the full W RUN cycles, with no early termination.

Reset
REQ-023 When rst_n=0 at a rising edge, the FSM SHALL go to IDLE from any state, including mid-RUN, discarding the operation in progress.
REQ-024 Reset SHALL set product=0, busy=0, done=0, the accumulator=0 and k=0.
REQ-025 A start sampled in the same cycle as rst_n=0 SHALL be ignored.
REQ-026 The first start SHALL be accepted on the first edge with rst_n=1.

Structure
REQ-027 A shared package mult_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the default width constant.
REQ-028 The step-counter width, clog2(W)+1, SHALL be derived in the package.
REQ-029 The partial-product row SHALL be a separate combinational sub-module, pp_row, with W-bit m, 1-bit q and W-bit pp = m AND q per bit.
REQ-030 The FSM, counter and accumulator SHALL live in seq_mult_4bit.

Verification
REQ-031 a=3, b=5, start pulse -> busy=1 from edge 1; done=1 after edge 5; product=15; busy=0 after edge 6.
REQ-032 a=15, b=15 -> product=225 (0xE1) with done after edge 5; a=0, b=9 -> product=0 with done still after edge 5.
REQ-033 start held high throughout, with a and b changed to 7/7 during RUN, for an initial 2*6 -> single result 12; the next start accepted on the edge after DONE, giving 49 six edges later.
REQ-034 rst_n=0 at edge 3 of a 9*9 run -> product=0, busy=0, done never pulses; a subsequent 9*9 -> 81.
REQ-035 Exhaustive sweep of all 256 a/b pairs with back-to-back starts -> every product equals a*b and every done pulse is exactly one cycle wide.
